// File: rtl/vga_mon_pkg.sv
// Shared timing defaults, monitor state encoding and the CRC-16-CCITT byte step
// used by the VGA sync monitor.
package vga_mon_pkg;

  localparam int unsigned H_VISIBLE_DEF = 640;
  localparam int unsigned H_FRONT_DEF   = 16;
  localparam int unsigned H_SYNC_DEF    = 96;
  localparam int unsigned H_BACK_DEF    = 48;
  localparam int unsigned V_VISIBLE_DEF = 480;
  localparam int unsigned V_FRONT_DEF   = 10;
  localparam int unsigned V_SYNC_DEF    = 2;
  localparam int unsigned V_BACK_DEF    = 33;

  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  localparam logic [15:0] CRC_POLY = 16'h1021;

  typedef enum logic [1:0] {
    HUNT,
    ACQUIRE,
    LOCKED
  } mon_state_e;

  function automatic int unsigned h_total(input int unsigned vis, input int unsigned front,
                                          input int unsigned sync, input int unsigned back);
    return vis + front + sync + back;
  endfunction

  function automatic int unsigned v_total(input int unsigned vis, input int unsigned front,
                                          input int unsigned sync, input int unsigned back);
    return vis + front + sync + back;
  endfunction

  // MSB-first CRC-16-CCITT update over one byte.
  function automatic logic [15:0] crc16_ccitt_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/vga_mon_crc16.sv
// Running CRC-16-CCITT over a byte stream; init has priority over enable.
module vga_mon_crc16
  import vga_mon_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_i,
  input  logic        init_i,
  input  logic [7:0]  data_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      crc_q <= CRC_INIT;
    end else if (init_i) begin
      crc_q <= CRC_INIT;
    end else if (en_i) begin
      crc_q <= crc16_ccitt_byte(crc_q, data_i);
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/vga_sync_monitor.sv
// VGA sync checker: measures hsync/vsync timing, locks after clean frames, recovers
// de/px_x/px_y. Optional visible-pixel CRC is built when VGA_MON_RGB_CRC_EN is defined.
module vga_sync_monitor
  import vga_mon_pkg::*;
#(
  parameter int unsigned H_VISIBLE   = H_VISIBLE_DEF,
  parameter int unsigned H_FRONT     = H_FRONT_DEF,
  parameter int unsigned H_SYNC      = H_SYNC_DEF,
  parameter int unsigned H_BACK      = H_BACK_DEF,
  parameter int unsigned V_VISIBLE   = V_VISIBLE_DEF,
  parameter int unsigned V_FRONT     = V_FRONT_DEF,
  parameter int unsigned V_SYNC      = V_SYNC_DEF,
  parameter int unsigned V_BACK      = V_BACK_DEF,
  parameter bit          SYNC_POL    = 1'b0,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_en,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [7:0]  rgb,
  output logic        locked,
  output logic        de,
  output logic [9:0]  px_x,
  output logic [9:0]  px_y,
  output logic        h_err,
  output logic        v_err,
  output logic [15:0] frame_cnt,
  output logic [7:0]  err_cnt,
  output logic [15:0] frame_crc
);

  localparam int unsigned H_TOTAL = h_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned V_TOTAL = v_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

  localparam logic [10:0] H_LEAD_EXP  = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_TRAIL_EXP = 11'(H_SYNC - 1);
  localparam logic [10:0] H_DE_FIRST  = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] H_DE_LAST   = 11'(H_SYNC + H_BACK + H_VISIBLE - 1);
  localparam logic [9:0]  V_LEAD_EXP  = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_TRAIL_EXP = 10'(V_SYNC - 1);
  localparam logic [9:0]  V_DE_FIRST  = 10'(V_SYNC + V_BACK);
  localparam logic [9:0]  V_DE_LAST   = 10'(V_SYNC + V_BACK + V_VISIBLE - 1);
  localparam logic [3:0]  LOCK_N      = 4'(LOCK_FRAMES);

  logic [10:0] h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  logic        hs_prev_q, vs_prev_q;
  mon_state_e  state_q;
  logic [3:0]  good_q;
  logic        locked_q, de_q, h_err_q, v_err_q;
  logic [9:0]  px_x_q, px_y_q;
  logic [15:0] frame_cnt_q;
  logic [7:0]  err_cnt_q;

  logic hs_act, vs_act, h_lead, h_trail, v_lead, v_trail;
  logic h_mis, v_mis, active, any_err, de_d;
  logic [9:0] px_x_d, px_y_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    hs_act  = (hsync == SYNC_POL);
    vs_act  = (vsync == SYNC_POL);
    h_lead  = hs_act & ~hs_prev_q;
    h_trail = ~hs_act & hs_prev_q;
    v_lead  = h_lead & vs_act & ~vs_prev_q;
    v_trail = h_lead & ~vs_act & vs_prev_q;

    // Checks look at the count before this tick's update.
    h_mis = (h_lead && (h_cnt_q != H_LEAD_EXP)) || (h_trail && (h_cnt_q != H_TRAIL_EXP));
    v_mis = (v_lead && (v_cnt_q != V_LEAD_EXP)) || (v_trail && (v_cnt_q != V_TRAIL_EXP));

    h_cnt_d = (h_cnt_q == 11'h7FF) ? h_cnt_q : h_cnt_q + 11'd1;
    if (h_lead) h_cnt_d = '0;

    v_cnt_d = v_cnt_q;
    if (v_lead)      v_cnt_d = '0;
    else if (h_lead) v_cnt_d = (v_cnt_q == 10'h3FF) ? v_cnt_q : v_cnt_q + 10'd1;

    de_d = (h_cnt_d >= H_DE_FIRST) && (h_cnt_d <= H_DE_LAST) &&
           (v_cnt_d >= V_DE_FIRST) && (v_cnt_d <= V_DE_LAST);
    px_x_d = '0;
    px_y_d = '0;
    if (de_d) begin
      px_x_d = 10'(h_cnt_d - H_DE_FIRST);
      px_y_d = v_cnt_d - V_DE_FIRST;
    end

    active  = (state_q != HUNT);
    any_err = active & (h_mis | v_mis);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      hs_prev_q   <= 1'b0;
      vs_prev_q   <= 1'b0;
      state_q     <= HUNT;
      good_q      <= '0;
      locked_q    <= 1'b0;
      de_q        <= 1'b0;
      px_x_q      <= '0;
      px_y_q      <= '0;
      h_err_q     <= 1'b0;
      v_err_q     <= 1'b0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every register
      // samples the pre-edge values regardless of statement order.
      h_err_q <= 1'b0;
      v_err_q <= 1'b0;
      if (pix_en) begin
        hs_prev_q <= hs_act;
        if (h_lead) vs_prev_q <= vs_act;
        h_cnt_q <= h_cnt_d;
        v_cnt_q <= v_cnt_d;
        de_q    <= de_d;
        px_x_q  <= px_x_d;
        px_y_q  <= px_y_d;
        h_err_q <= active & h_mis;
        v_err_q <= active & v_mis;
        if (v_lead && active) frame_cnt_q <= frame_cnt_q + 16'd1;

        if (any_err) begin
          if (state_q == LOCKED && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
          state_q  <= HUNT;
          locked_q <= 1'b0;
        end else if (v_lead) begin
          case (state_q)
            HUNT: begin
              state_q <= ACQUIRE;
              good_q  <= '0;
            end
            ACQUIRE: begin
              good_q <= good_q + 4'd1;
              if (good_q + 4'd1 == LOCK_N) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

`ifdef VGA_MON_RGB_CRC_EN
  logic [15:0] crc_run;
  logic [15:0] frame_crc_q;

  vga_mon_crc16 u_crc (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (pix_en & de_d),
    .init_i (pix_en & v_lead),
    .data_i (rgb),
    .crc_o  (crc_run)
  );

  always_ff @(posedge clk) begin
    if (!rst_n)                frame_crc_q <= '0;
    else if (pix_en && v_lead) frame_crc_q <= crc_run;
  end

  assign frame_crc = frame_crc_q;
`else
  logic unused_rgb;
  assign unused_rgb = ^rgb;
  assign frame_crc  = '0;
`endif

  assign locked    = locked_q;
  assign de        = de_q;
  assign px_x      = px_x_q;
  assign px_y      = px_y_q;
  assign h_err     = h_err_q;
  assign v_err     = v_err_q;
  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: doc/vga_sync_monitor.md
# vga_sync_monitor

Receive-side checker for the VGA stream produced by the `vgaPong` display path. It samples `hsync`/`vsync`/`rgb` on pixel-enable ticks and measures sync pulse widths and periods against 640x480@60 timing. It declares lock after consecutive clean frames, recovers pixel coordinates and data-enable, and counts frames and errors. It sits beside the VGA output pins for on-chip self-test and in benches as the sink/scoreboard.

## Interface
- `H_VISIBLE`, 640, visible pixels per line
- `H_FRONT` / `H_SYNC` / `H_BACK`, 16 / 96 / 48, horizontal porch and sync widths in pixel ticks
- `V_VISIBLE`, 480, visible lines per frame
- `V_FRONT` / `V_SYNC` / `V_BACK`, 10 / 2 / 33, vertical porch and sync widths in lines
- `SYNC_POL`, 0, asserted level of both syncs (0 = active-low)
- `LOCK_FRAMES`, 2, consecutive clean frames required to lock (1..15)
- `clk  in  1` system clock
- `rst_n  in  1` reset, synchronous, active-low; one clock, all logic on `clk` rising edge
- `pix_en  in  1` pixel tick; inputs are sampled only when high
- `hsync  in  1`, `vsync  in  1` sync inputs
- `rgb  in  8` pixel colour, 3-3-2
- `locked  out  1` timing lock
- `de  out  1` recovered visible-area flag
- `px_x  out  10`, `px_y  out  10` recovered coordinates; 0 outside the visible area
- `h_err  out  1`, `v_err  out  1` one-clk error pulses
- `frame_cnt  out  16` frames seen, wraps
- `err_cnt  out  8` errors while locked, saturates at 255
- `frame_crc  out  16` CRC of the last complete frame's visible pixels

## Operation
- Derived values: `H_TOTAL` = sum of horizontal widths (800); `V_TOTAL` = sum of vertical widths (525).
- Horizontal counter `h_cnt` (11 bit):
  - Zeroed on an hsync leading edge (previous tick deasserted, this tick asserted).
  - Otherwise increments, saturating at 2047.
- Horizontal checks:
  - At a leading edge, the pre-update `h_cnt` must equal `H_TOTAL-1`.
  - At a trailing edge, it must equal `H_SYNC-1`.
  - A mismatch is an h error.
- Vertical timing:
  - vsync is sampled only on hsync leading edges.
  - `v_cnt` (10 bit) zeroes on a vsync leading edge and otherwise increments per line, saturating.
  - Checks: `V_TOTAL-1` at the leading edge, `V_SYNC-1` at the trailing edge; a mismatch is a v error.
- Visible area:
  - `de` = (`h_cnt` in `H_SYNC+H_BACK` .. +`H_VISIBLE-1`) and (`v_cnt` in `V_SYNC+V_BACK` .. +`V_VISIBLE-1`).
  - `px_x`/`px_y` are the offsets from those starts.
- States:
  - HUNT → ACQUIRE on the first vsync leading edge; `good` cleared.
  - ACQUIRE: each vsync leading edge with no error since the previous edge increments `good`. When `good == LOCK_FRAMES`, go to LOCKED. Any error returns to HUNT.
  - LOCKED: any error returns to HUNT, drops `locked`, and increments `err_cnt` once.
- Error pulses: `h_err`/`v_err` pulse only in ACQUIRE/LOCKED; HUNT ignores mismatches.
- Simultaneous h and v errors: both pulses assert, `err_cnt` increments by 1.
- `frame_cnt` increments on every vsync leading edge in ACQUIRE/LOCKED.

## Timing
- `pix_en` low: all state and outputs hold.
- Outputs are registered and update on the `clk` edge where `pix_en`=1. They reflect the inputs sampled on that edge (1-clk latency). Edge detection uses the previous sampled tick.
- `locked` rises 1 clk after the vsync edge closing the `LOCK_FRAMES`th clean frame. With the default, that is the 3rd vsync edge after reset.
- `locked` falls in the same cycle as the error pulse.
- Reset, including mid-frame: all outputs 0, `err_cnt`/`frame_cnt` 0, counters 0, state HUNT, CRC register at its init value.
- Saturated `h_cnt`/`v_cnt` (sync lost) produce an error at the next edge, not a wrap.

## Configuration
- `VGA_MON_RGB_CRC_EN` defined:
  - CRC-16-CCITT (poly 0x1021, init 0xFFFF) over `rgb` on every `de` tick.
  - Latched to `frame_crc` and re-initialised at each vsync leading edge.
- Undefined: no CRC logic; `frame_crc` tied to 0; `rgb` unused.

## Structure
- `vga_mon_pkg`: default 640x480 timing constants, `H_TOTAL`/`V_TOTAL` functions, state enum (HUNT, ACQUIRE, LOCKED).
- Sub-module `vga_mon_crc16`: one-byte CRC step with enable and init. Instantiated only under `VGA_MON_RGB_CRC_EN`.

## Test plan
- Clean stream, `pix_en` every 2nd clk, `rgb`=8'h00:
  - `locked`=1 one clk after the 3rd vsync edge.
  - `frame_cnt` = frames−1; `err_cnt`=0.
  - `de` high for 307200 ticks per frame; `px_x` max 639, `px_y` max 479.
- While locked, one line of 801 ticks → `h_err` pulse at the next hsync leading edge, `locked`=0, `err_cnt`=1; relock after 2 clean frames.
- hsync width 95 ticks while locked → `h_err` at the trailing edge, `err_cnt`+1.
- vsync width 3 lines together with a simultaneous h error → both pulses in one cycle, `err_cnt`+1 only.
- `rst_n`=0 for 1 clk mid-frame while locked → all outputs 0 next cycle, state HUNT, relock after 3 vsync edges.
- CRC build:
  - Two identical frames → identical nonzero `frame_crc`.
  - Changing the pixel at (0,0) from 8'h00 to 8'h01 → a different `frame_crc`.
